// File: rtl/prbs7_ber_monitor.sv
// rtl/prbs7_ber_monitor.sv - lock-aware PRBS7 (x^7+x^6+1, LSB-first) bit-error-rate monitor
//
// Purpose:
//   Consumes aligned 32-bit RX words and self-synchronises a PRBS7 reference.
//   Lock is declared after LOCK_CNT consecutive predicted words. While locked,
//   a free-running reference is compared against each word, and saturating
//   counters accumulate bit errors, errored words and checked words.
//
// Optional build macro:
//   PRBS7_BER_MONITOR_INVERT_EN - adds rx_invert; when high, din is inverted
//   before any processing (swapped P/N lanes). Latency is unchanged.
//
// Ports:
//   clk            in   RX user clock
//   reset          in   synchronous, active-high
//   din            in   aligned received word, bit 0 first in time
//   din_valid      in   din carries a word this cycle
//   clear          in   synchronous clear of the three counters
//   rx_invert      in   (macro only) invert din before processing
//   locked         out  checker is in LOCKED
//   err_flag       out  last checked word had at least one bit error
//   word_bit_errs  out  bit errors in the last checked word (0..32)
//   bit_err_cnt    out  accumulated bit errors while locked, saturating
//   err_word_cnt   out  accumulated errored words while locked, saturating
//   word_cnt       out  accumulated words checked while locked, saturating

module prbs7_ber_monitor #(
    parameter int WORDWIDTH  = 32,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int BAD_THRESH = 4,
    parameter int BITCNT_W   = 32,
    parameter int WORDCNT_W  = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORDWIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 clear,
`ifdef PRBS7_BER_MONITOR_INVERT_EN
    input  logic                 rx_invert,
`endif
    output logic                 locked,
    output logic                 err_flag,
    output logic [5:0]           word_bit_errs,
    output logic [BITCNT_W-1:0]  bit_err_cnt,
    output logic [WORDCNT_W-1:0] err_word_cnt,
    output logic [WORDCNT_W-1:0] word_cnt
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Sum width for the bit-error accumulator: wide enough for a 6-bit
    // increment plus one carry bit to detect overflow.
    localparam int BSW = ((BITCNT_W > 6) ? BITCNT_W : 6) + 1;
    localparam logic [BSW-1:0] BIT_MAX = BSW'({BITCNT_W{1'b1}});

    // Next 32 bits of the sequence given the previous 32 bits (pure XOR).
    function automatic logic [31:0] prbs7_next(input logic [31:0] w);
        logic [63:0] s;
        s = {32'd0, w};
        for (int j = 32; j < 64; j++) begin
            s[j] = s[j-7] ^ s[j-6];
        end
        return s[63:32];
    endfunction

    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    state_t                 state_q, state_d;
    // Holds the previous received word in HUNT and the free-running
    // reference in LOCKED; the two roles never overlap.
    logic [31:0]            ref_q, ref_d;
    logic                   have_prev_q, have_prev_d;
    logic [7:0]             good_run_q, good_run_d;
    logic [7:0]             bad_run_q, bad_run_d;
    logic                   err_flag_q, err_flag_d;
    logic [5:0]             wbe_q, wbe_d;
    logic [BITCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORDCNT_W-1:0]   ew_cnt_q, ew_cnt_d;
    logic [WORDCNT_W-1:0]   w_cnt_q, w_cnt_d;

    logic [31:0]            din_eff;
    logic [31:0]            pred;
    logic [5:0]             pc;
    logic                   match;
    logic [BITCNT_W-1:0]    bit_base;
    logic [WORDCNT_W-1:0]   ew_base;
    logic [WORDCNT_W-1:0]   w_base;
    logic [BSW-1:0]         bit_sum;
    logic [BITCNT_W-1:0]    bit_next;
    logic [WORDCNT_W-1:0]   ew_next;
    logic [WORDCNT_W-1:0]   w_next;

`ifdef PRBS7_BER_MONITOR_INVERT_EN
    assign din_eff = din ^ {32{rx_invert}};
`else
    assign din_eff = din;
`endif

    assign pred  = prbs7_next(ref_q);
    assign pc    = popcnt32(din_eff ^ pred);
    // An all-zero word is the LFSR lockup state and must never look like a match.
    assign match = (din_eff == pred) && (din_eff != 32'd0);

    // clear is applied first so a coincident counted word leaves only its own increment.
    assign bit_base = clear ? '0 : bit_cnt_q;
    assign ew_base  = clear ? '0 : ew_cnt_q;
    assign w_base   = clear ? '0 : w_cnt_q;

    assign bit_sum  = BSW'(bit_base) + BSW'(pc);
    assign bit_next = (bit_sum > BIT_MAX) ? '1 : bit_sum[BITCNT_W-1:0];
    assign w_next   = (&w_base) ? w_base : w_base + WORDCNT_W'(1);
    assign ew_next  = ((pc == 6'd0) || (&ew_base)) ? ew_base : ew_base + WORDCNT_W'(1);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        have_prev_d = have_prev_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        err_flag_d  = err_flag_q;
        wbe_d       = wbe_q;
        bit_cnt_d   = bit_base;
        ew_cnt_d    = ew_base;
        w_cnt_d     = w_base;

        case (state_q)
            ST_HUNT: begin
                if (din_valid) begin
                    err_flag_d  = 1'b0;
                    wbe_d       = 6'd0;
                    ref_d       = din_eff;
                    have_prev_d = 1'b1;
                    if (have_prev_q) begin
                        if (match) begin
                            if (good_run_q == 8'(LOCK_CNT - 1)) begin
                                // din becomes the reference seed for LOCKED.
                                state_d    = ST_LOCKED;
                                good_run_d = 8'd0;
                                bad_run_d  = 8'd0;
                            end else begin
                                good_run_d = good_run_q + 8'd1;
                            end
                        end else begin
                            good_run_d = 8'd0;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (din_valid) begin
                    // Reference advances from itself, never from din.
                    ref_d      = pred;
                    wbe_d      = pc;
                    err_flag_d = (pc != 6'd0);
                    bit_cnt_d  = bit_next;
                    ew_cnt_d   = ew_next;
                    w_cnt_d    = w_next;
                    if (pc > 6'(BAD_THRESH)) begin
                        if (bad_run_q == 8'(UNLOCK_CNT - 1)) begin
                            state_d     = ST_HUNT;
                            have_prev_d = 1'b1;
                            ref_d       = din_eff;
                            good_run_d  = 8'd0;
                            bad_run_d   = 8'd0;
                        end else begin
                            bad_run_d = bad_run_q + 8'd1;
                        end
                    end else begin
                        bad_run_d = 8'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            ref_q       <= 32'd0;
            have_prev_q <= 1'b0;
            good_run_q  <= 8'd0;
            bad_run_q   <= 8'd0;
            err_flag_q  <= 1'b0;
            wbe_q       <= 6'd0;
            bit_cnt_q   <= '0;
            ew_cnt_q    <= '0;
            w_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            have_prev_q <= have_prev_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            err_flag_q  <= err_flag_d;
            wbe_q       <= wbe_d;
            bit_cnt_q   <= bit_cnt_d;
            ew_cnt_q    <= ew_cnt_d;
            w_cnt_q     <= w_cnt_d;
        end
    end

    assign locked        = (state_q == ST_LOCKED);
    assign err_flag      = err_flag_q;
    assign word_bit_errs = wbe_q;
    assign bit_err_cnt   = bit_cnt_q;
    assign err_word_cnt  = ew_cnt_q;
    assign word_cnt      = w_cnt_q;

endmodule

// File: tb/tb_prbs7_ber_monitor.sv
// tb/tb_prbs7_ber_monitor.sv - self-checking bench for prbs7_ber_monitor

module tb_prbs7_ber_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_valid;
    logic        clear;
    logic        rx_invert;
    logic        locked;
    logic        err_flag;
    logic [5:0]  word_bit_errs;
    logic [7:0]  bit_err_cnt;
    logic [47:0] err_word_cnt;
    logic [47:0] word_cnt;

    int vectors;
    int miscompares;

    // Serial PRBS7 generator: window holds the next 7 stream bits.
    logic [6:0]  win;
    logic [31:0] w;
    logic [31:0] m;
    int          tot, ew, wc, k;
    logic        got;

    prbs7_ber_monitor #(
        .WORDWIDTH (32),
        .LOCK_CNT  (8),
        .UNLOCK_CNT(4),
        .BAD_THRESH(4),
        .BITCNT_W  (8),
        .WORDCNT_W (48)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .clear        (clear),
`ifdef PRBS7_BER_MONITOR_INVERT_EN
        .rx_invert    (rx_invert),
`endif
        .locked       (locked),
        .err_flag     (err_flag),
        .word_bit_errs(word_bit_errs),
        .bit_err_cnt  (bit_err_cnt),
        .err_word_cnt (err_word_cnt),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic gen_word(output logic [31:0] o);
        logic nb;
        for (int i = 0; i < 32; i++) begin
            o[i] = win[0];
            nb   = win[0] ^ win[1];
            win  = {nb, win[6:1]};
        end
    endtask

    function automatic logic [31:0] rand_mask(input int n);
        logic [31:0] r;
        r = 32'd0;
        while ($countones(r) < n) r[$urandom_range(31, 0)] = 1'b1;
        return r;
    endfunction

    task automatic cyc(input logic v, input logic [31:0] d, input logic clr);
        din_valid = v;
        din       = d;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        repeat (g) cyc(1'b0, $urandom, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        win         = 7'h7F;
        reset       = 1'b1;
        din_valid   = 1'b0;
        din         = 32'd0;
        clear       = 1'b0;
        rx_invert   = 1'b0;

        repeat (3) cyc(1'b1, $urandom, 1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_wbe", word_bit_errs, 0);
        chk("rst_bits", bit_err_cnt, 0);
        chk("rst_errwords", err_word_cnt, 0);
        chk("rst_words", word_cnt, 0);
        reset = 1'b0;

        // Seed word + 8 matches; locked visible right after the 9th word's edge.
        for (int i = 0; i < 9; i++) begin
            gen_word(w);
            cyc(1'b1, w, 1'b0);
            chk("lock_seq", locked, (i == 8));
            chk("lock_seq_noflag", err_flag, 0);
        end

        for (int n = 0; n < 1000; n++) begin
            gap();
            gen_word(w);
            cyc(1'b1, w, 1'b0);
        end
        chk("clean_words", word_cnt, 1000);
        chk("clean_bits", bit_err_cnt, 0);
        chk("clean_errwords", err_word_cnt, 0);
        chk("clean_locked", locked, 1);

        gen_word(w);
        cyc(1'b1, w ^ 32'h0000_0020, 1'b0);
        chk("bit5_flag", err_flag, 1);
        chk("bit5_wbe", word_bit_errs, 1);
        chk("bit5_bits", bit_err_cnt, 1);
        chk("bit5_errwords", err_word_cnt, 1);
        chk("bit5_words", word_cnt, 1001);
        gen_word(w);
        cyc(1'b1, w, 1'b0);
        chk("bit5_next_flag", err_flag, 0);
        chk("bit5_next_wbe", word_bit_errs, 0);
        chk("bit5_next_bits", bit_err_cnt, 1);

        cyc(1'b0, $urandom, 1'b1);
        chk("clr_bits", bit_err_cnt, 0);
        chk("clr_errwords", err_word_cnt, 0);
        chk("clr_words", word_cnt, 0);
        chk("clr_locked", locked, 1);

        // Random non-bad errors; 8-bit bit counter runs into saturation.
        tot = 0; ew = 0; wc = 0;
        for (int n = 0; n < 300; n++) begin
            gap();
            k = $urandom_range(0, 4);
            m = rand_mask(k);
            gen_word(w);
            cyc(1'b1, w ^ m, 1'b0);
            tot += k;
            if (k != 0) ew++;
            wc++;
            chk("rnd_flag", err_flag, (k != 0));
            chk("rnd_wbe", word_bit_errs, k);
            chk("rnd_bits", bit_err_cnt, (tot > 255) ? 255 : tot);
            chk("rnd_errwords", err_word_cnt, ew);
            chk("rnd_words", word_cnt, wc);
            chk("rnd_locked", locked, 1);
        end

        m = rand_mask(3);
        gen_word(w);
        cyc(1'b1, w ^ m, 1'b1);
        chk("clrword_bits", bit_err_cnt, 3);
        chk("clrword_errwords", err_word_cnt, 1);
        chk("clrword_words", word_cnt, 1);
        chk("clrword_wbe", word_bit_errs, 3);
        cyc(1'b0, 32'd0, 1'b1);
        chk("clr2_bits", bit_err_cnt, 0);
        chk("clr2_words", word_cnt, 0);
        chk("clr2_locked", locked, 1);

        for (int i = 0; i < 4; i++) begin
            gen_word(w);
            cyc(1'b1, ~w, 1'b0);
            chk("unlock_seq", locked, (i < 3));
            chk("unlock_wbe", word_bit_errs, 32);
        end
        chk("unlock_bits", bit_err_cnt, 128);
        chk("unlock_errwords", err_word_cnt, 4);
        chk("unlock_words", word_cnt, 4);

        gen_word(w);
        cyc(1'b1, w, 1'b0);
        chk("hunt_hold_bits", bit_err_cnt, 128);
        chk("hunt_flag", err_flag, 0);
        chk("hunt_locked", locked, 0);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (!got) begin
                gen_word(w);
                cyc(1'b1, w, 1'b0);
                got = locked;
            end
        end
        chk("relock", got, 1);
        chk("relock_bits", bit_err_cnt, 128);
        chk("relock_words", word_cnt, 4);
        for (int n = 0; n < 10; n++) begin
            gen_word(w);
            cyc(1'b1, w, 1'b0);
        end
        chk("relock_more_words", word_cnt, 14);
        chk("relock_more_bits", bit_err_cnt, 128);

        reset = 1'b1;
        cyc(1'b1, $urandom, 1'b1);
        reset = 1'b0;
        chk("midrst_locked", locked, 0);
        chk("midrst_words", word_cnt, 0);
        chk("midrst_bits", bit_err_cnt, 0);
        chk("midrst_flag", err_flag, 0);
        for (int n = 0; n < 100; n++) begin
            cyc(1'b1, 32'd0, 1'b0);
            chk("zeros_locked", locked, 0);
        end

`ifdef PRBS7_BER_MONITOR_INVERT_EN
        reset = 1'b1;
        cyc(1'b0, 32'd0, 1'b0);
        reset     = 1'b0;
        win       = 7'h7F;
        rx_invert = 1'b1;
        for (int i = 0; i < 9; i++) begin
            gen_word(w);
            cyc(1'b1, ~w, 1'b0);
            chk("inv_lock_seq", locked, (i == 8));
        end
        for (int n = 0; n < 50; n++) begin
            gen_word(w);
            cyc(1'b1, ~w, 1'b0);
        end
        chk("inv_words", word_cnt, 50);
        chk("inv_bits", bit_err_cnt, 0);
        reset = 1'b1;
        cyc(1'b0, 32'd0, 1'b0);
        reset     = 1'b0;
        rx_invert = 1'b0;
        for (int n = 0; n < 100; n++) begin
            gen_word(w);
            cyc(1'b1, ~w, 1'b0);
            chk("noinv_locked", locked, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
